regfile_mp: RTL
===============

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width in bits.
REQ-002 Parameter NREGS, default 32, register count; power of two, >= 2; AW = log2(NREGS).
REQ-003 Parameter NRD, default 2, number of read ports, 1..4.
REQ-004 Parameter NWR, default 2, number of write ports, 1..2.
REQ-005 Parameter BYPASS, default 1; 1 = write-to-read forwarding enabled, 0 = disabled.
REQ-006 Port clk_i, input, 1, single clock; all state changes on its rising edge.
REQ-007 Port rst_i, input, 1, reset; synchronous and active-high.
REQ-008 Port rd_en_i, input, NRD, per-port read enable.
REQ-009 Port rd_addr_i, input, NRD x AW, per-port read address.
REQ-010 Port rd_data_o, output, NRD x XLEN, registered read data.
REQ-011 Port wr_en_i, input, NWR, per-port write enable.
REQ-012 Port wr_addr_i, input, NWR x AW, per-port write address.
REQ-013 Port wr_data_i, input, NWR x XLEN, per-port write data.
REQ-014 Port ready_o, output, 1, high when the initial clear has completed and the file accepts accesses.
REQ-015 Port conflict_o, output, 1, one-cycle flag for a same-address dual write.

Function
REQ-016 The block SHALL have FSM states CLEAR and READY.
REQ-017 In CLEAR, an internal counter SHALL write zero to register cnt each cycle, for cnt = 1 .. NREGS-1.
REQ-018 CLEAR SHALL go to READY on the edge that clears register NREGS-1; ready_o = (state == READY), registered.
REQ-019 While in CLEAR, wr_en_i SHALL be ignored, rd_data_o SHALL hold 0, and conflict_o SHALL be 0.
REQ-020 Register 0 SHALL always read as 0; writes to address 0 SHALL be discarded and SHALL NOT trigger a bypass.
REQ-021 Reads SHALL have 1-cycle latency: rd_data_o[p] is updated on the edge after rd_en_i[p] is sampled high.
REQ-022 When rd_en_i[p] = 0, rd_data_o[p] SHALL hold its previous value.
REQ-023 With BYPASS = 1, a read of nonzero address A in the same cycle as an enabled write to A SHALL return the new write data.
REQ-024 With BYPASS = 0, such a read SHALL return the old contents of A.
REQ-025 If both write ports are enabled to the same nonzero address, port 1 SHALL win for both storage and bypass.
REQ-026 In the case of REQ-025, conflict_o SHALL be 1 for exactly the following cycle.
REQ-027 Writes to different addresses SHALL both commit in the same edge.
REQ-028 Multiple read ports addressing the same register SHALL all return identical data.

Reset
REQ-029 rst_i = 1 sampled at an edge SHALL force state = CLEAR, cnt = 1, rd_data_o = 0, conflict_o = 0 and ready_o = 0.
REQ-030 Reset asserted during CLEAR or READY SHALL restart the clear sequence from register 1.
REQ-031 Register contents are not required to be zero at reset assertion; only the clear sequence guarantees zero.
REQ-032 With NREGS = 32, ready_o SHALL rise 31 edges after the last edge at which rst_i was sampled high.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the FSM state enum (CLEAR, READY) and the default XLEN and NREGS constants.
REQ-034 The address width AW SHALL be derived inside the module with $clog2.
REQ-035 A single sub-module, regfile_wr_arb, SHALL resolve write-port priority and conflict detection, and produce the per-register write enable and data.
REQ-036 Read ports and bypass muxes SHALL be generated with a generate loop over NRD.

Verification
REQ-037 Release reset, then read every address on every port after ready_o rises -> every read returns 0x00000000; ready_o rises exactly 31 edges after release.
REQ-038 Write 0xDEADBEEF to address 5, then read address 5 on the next cycle -> 0xDEADBEEF; write 0x12345678 to address 0 -> address 0 reads 0.
REQ-039 BYPASS = 1: write 0xA5A5A5A5 to address 7 while reading address 7 on port 0 in the same cycle -> rd_data_o[0] = 0xA5A5A5A5 one edge later; BYPASS = 0 -> the old value is returned.
REQ-040 Port 0 writes 0x11111111 and port 1 writes 0x22222222, both to address 9 -> conflict_o = 1 for one cycle; address 9 reads 0x22222222.
REQ-041 Assert rst_i at cnt = 10 during CLEAR, and separately in READY after writing 0xFFFFFFFF to address 3 -> the clear restarts at register 1; after ready_o rises, address 3 reads 0.
REQ-042 Hold rd_en_i[1] = 0 while the addressed register changes -> rd_data_o[1] stays at its previously latched value.

Source files
------------

// File: rtl/regfile_pkg.sv
// ---------------------------------------------------------------------------
// regfile_pkg
//   Shared definitions for the multi-ported register file:
//     - rf_state_e : FSM state (CLEAR while zeroing the file, READY for use)
//     - XLEN_DEF   : default data width in bits
//     - NREGS_DEF  : default register count
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_wr_arb.sv
// ---------------------------------------------------------------------------
// regfile_wr_arb
//   Turns the write ports into one write enable and one write-data word per
//   register. A higher-numbered port overrides a lower one that targets the
//   same register, so port 1 wins a same-address dual write. Writes to
//   register 0 are dropped here, so they never reach storage or the bypass.
//
//   Ports
//     active    : writes are accepted only while high (file READY, no reset)
//     wr_en     : per-port write enable            [NWR]
//     wr_addr   : per-port write address           [NWR][AW]
//     wr_data   : per-port write data              [NWR][XLEN]
//     reg_we    : per-register write enable        [NREGS]
//     reg_wdata : per-register write data          [NREGS][XLEN]
//     conflict  : both ports write the same nonzero register this cycle
// ---------------------------------------------------------------------------
module regfile_wr_arb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWR   = 2
) (
  input  logic                                 active,
  input  logic [NWR-1:0]                       wr_en,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0]    wr_addr,
  input  logic [NWR-1:0][XLEN-1:0]             wr_data,
  output logic [NREGS-1:0]                     reg_we,
  output logic [NREGS-1:0][XLEN-1:0]           reg_wdata,
  output logic                                 conflict
);

  // NOTE: every output gets a default before the loop, so no path through
  // this block leaves a value unassigned and no latch is inferred.
  always_comb begin
    reg_we    = '0;
    reg_wdata = '0;
    // Ascending port order: the last enabled port on an address wins.
    for (int p = 0; p < NWR; p++) begin
      if (active && wr_en[p] && (wr_addr[p] != '0)) begin
        reg_we[wr_addr[p]]    = 1'b1;
        reg_wdata[wr_addr[p]] = wr_data[p];
      end
    end
  end

  if (NWR == 2) begin : g_conflict
    assign conflict = active && (&wr_en) &&
                      (wr_addr[0] == wr_addr[1]) && (wr_addr[0] != '0);
  end else begin : g_no_conflict
    assign conflict = 1'b0;
  end

endmodule

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//   Multi-ported register file with NRD registered read ports and NWR write
//   ports. Register 0 always reads as zero. After reset the file walks a
//   counter over registers 1..NREGS-1 writing zero (CLEAR), then raises
//   ready_o (READY). Optional write-to-read forwarding returns same-cycle
//   write data on a read of the register being written.
//
//   Ports
//     clk_i      : clock, all state changes on the rising edge
//     rst_i      : synchronous active-high reset, restarts the clear
//     rd_en_i    : per-port read enable             [NRD]
//     rd_addr_i  : per-port read address            [NRD][AW]
//     rd_data_o  : per-port registered read data    [NRD][XLEN]
//     wr_en_i    : per-port write enable            [NWR]
//     wr_addr_i  : per-port write address           [NWR][AW]
//     wr_data_i  : per-port write data              [NWR][XLEN]
//     ready_o    : clear finished, accesses accepted
//     conflict_o : one-cycle flag after a same-address dual write
//
//   Legal parameters: NREGS a power of two >= 2, NRD 1..4, NWR 1..2,
//   BYPASS 0 or 1.
// ---------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREGS  = NREGS_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NRD-1:0]                     rd_en_i,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0]  rd_addr_i,
  output logic [NRD-1:0][XLEN-1:0]           rd_data_o,
  input  logic [NWR-1:0]                     wr_en_i,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0]  wr_addr_i,
  input  logic [NWR-1:0][XLEN-1:0]           wr_data_i,
  output logic                               ready_o,
  output logic                               conflict_o
);

  localparam int AW = $clog2(NREGS);

  rf_state_e                   state;
  logic [AW-1:0]               cnt;
  logic                        wr_active;
  logic [NREGS-1:0]            reg_we;
  logic [NREGS-1:0][XLEN-1:0]  reg_wdata;
  logic                        wr_conflict;
  logic [XLEN-1:0]             mem [NREGS];

  // User writes are ignored during the clear and on a reset edge.
  assign wr_active = (state == READY) && !rst_i;

  regfile_wr_arb #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_wr_arb (
    .active    (wr_active),
    .wr_en     (wr_en_i),
    .wr_addr   (wr_addr_i),
    .wr_data   (wr_data_i),
    .reg_we    (reg_we),
    .reg_wdata (reg_wdata),
    .conflict  (wr_conflict)
  );

  // -------------------------------------------------------------------------
  // Control FSM: CLEAR walks cnt over 1..NREGS-1; the edge that clears the
  // last register also moves to READY and raises ready_o.
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= CLEAR;
      cnt        <= AW'(1);
      ready_o    <= 1'b0;
      conflict_o <= 1'b0;
    end else begin
      conflict_o <= wr_conflict;
      case (state)
        CLEAR: begin
          if (cnt == AW'(NREGS - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        READY: begin
          state   <= READY;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Storage. Entry 0 is never written; reads of address 0 are forced to zero.
  // -------------------------------------------------------------------------
  // NOTE: the array has no reset; the clear sequence is what guarantees zero
  // contents, so the storage needs no reset tree.
  always_ff @(posedge clk_i) begin
    for (int i = 1; i < NREGS; i++) begin
      if (state == CLEAR) begin
        if (cnt == AW'(i)) mem[i] <= '0;
      end else if (reg_we[i]) begin
        mem[i] <= reg_wdata[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Read ports: one registered port plus optional forwarding per NRD.
  // Because the arbiter already resolved priority and dropped address 0,
  // forwarding just picks that register's resolved write data.
  // -------------------------------------------------------------------------
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] rd_next;
    logic [XLEN-1:0] rd_q;

    assign addr = rd_addr_i[p];

    always_comb begin
      rd_next = mem[addr];
      if ((BYPASS != 0) && reg_we[addr]) rd_next = reg_wdata[addr];
      if (addr == '0) rd_next = '0;
    end

    always_ff @(posedge clk_i) begin
      if (rst_i || (state == CLEAR)) begin
        rd_q <= '0;
      end else if (rd_en_i[p]) begin
        rd_q <= rd_next;
      end
    end

    assign rd_data_o[p] = rd_q;
  end

endmodule
